// File: rtl/vfmul_sequencer_if.sv
// vfmul_sequencer_if: command, register-file, multiplier and status bundle.
// master = sequencer side; slave = decoder / register file / multiplier side.
interface vfmul_sequencer_if #(
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 5,
  parameter int VL_W   = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [VL_W-1:0]   cmd_vl;
  logic [ADDR_W-1:0] cmd_a_base;
  logic [ADDR_W-1:0] cmd_b_base;
  logic [ADDR_W-1:0] cmd_d_base;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [ELEM_W-1:0] rd_a_data;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [ELEM_W-1:0] rd_b_data;
  logic [ELEM_W-1:0] mul_a;
  logic [ELEM_W-1:0] mul_b;
  logic [ELEM_W-1:0] mul_y;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ELEM_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              flag_nan;
  logic              flag_inf;

  modport master (
    input  cmd_valid, cmd_vl,
    input  cmd_a_base, cmd_b_base, cmd_d_base,
    input  rd_a_data, rd_b_data, mul_y,
    output cmd_ready, rd_a_addr, rd_b_addr,
    output mul_a, mul_b,
    output wr_en, wr_addr, wr_data,
    output busy, done, flag_nan, flag_inf
  );

  modport slave (
    output cmd_valid, cmd_vl,
    output cmd_a_base, cmd_b_base, cmd_d_base,
    output rd_a_data, rd_b_data, mul_y,
    input  cmd_ready, rd_a_addr, rd_b_addr,
    input  mul_a, mul_b,
    input  wr_en, wr_addr, wr_data,
    input  busy, done, flag_nan, flag_inf
  );
endinterface

// File: rtl/vfmul_sequencer.sv
// vfmul_sequencer: streams element pairs into the FP32 multiplier, 1/cycle.
// Ports: clk, reset (async, high); bus (master): cmd, rd A/B, mul, wr, status.
module vfmul_sequencer #(
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 5,
  parameter int MAX_VL = 32,
  parameter int VL_W   = 6
) (
  input  logic clk,
  input  logic reset,
  vfmul_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, FIN
  } state_t;

  // One in-flight element slot.
  typedef struct packed {
    logic              v;
    logic              last;
    logic [ADDR_W-1:0] d;
  } slot_t;

  state_t            state;
  slot_t             p1;
  slot_t             p2;
  logic [ADDR_W-1:0] d_ptr;
  logic [VL_W-1:0]   rem;
  logic [VL_W-1:0]   vl_eff;
  logic              y_exp_max;
  logic              y_man_nz;
  logic              is_last;

  always_comb begin
    vl_eff = bus.cmd_vl;
    if (bus.cmd_vl > VL_W'(MAX_VL))
      vl_eff = VL_W'(MAX_VL);
  end

  assign y_exp_max = &bus.mul_y[ELEM_W-2 -: 8];
  assign y_man_nz  = |bus.mul_y[ELEM_W-10:0];
  assign is_last   = (rem == VL_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      p1            <= '0;
      p2            <= '0;
      d_ptr         <= '0;
      rem           <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_a_addr <= '0;
      bus.rd_b_addr <= '0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.flag_nan  <= 1'b0;
      bus.flag_inf  <= 1'b0;
    end else begin
      // Read data -> operand registers.
      p1.v    <= 1'b0;
      p1.last <= 1'b0;
      p2.v    <= p1.v;
      p2.last <= p1.v & p1.last;
      p2.d    <= p1.d;
      if (p1.v) begin
        bus.mul_a <= bus.rd_a_data;
        bus.mul_b <= bus.rd_b_data;
      end
      // Product -> write port; done rides with the last write.
      bus.wr_en <= p2.v;
      bus.done  <= p2.v & p2.last;
      if (p2.v) begin
        bus.wr_data <= bus.mul_y;
        bus.wr_addr <= p2.d;
        if (y_exp_max & y_man_nz)
          bus.flag_nan <= 1'b1;
        if (y_exp_max & ~y_man_nz)
          bus.flag_inf <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            d_ptr         <= bus.cmd_d_base;
            rem           <= vl_eff;
            bus.flag_nan  <= 1'b0;
            bus.flag_inf  <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (vl_eff == '0) begin
              state    <= FIN;
              bus.done <= 1'b1;
            end else begin
              state         <= ISSUE;
              bus.rd_a_addr <= bus.cmd_a_base;
              bus.rd_b_addr <= bus.cmd_b_base;
            end
          end
        end
        ISSUE: begin
          p1.v    <= 1'b1;
          p1.last <= is_last;
          p1.d    <= d_ptr;
          rem     <= rem - VL_W'(1);
          if (is_last) begin
            state <= DRAIN;
          end else begin
            bus.rd_a_addr <= bus.rd_a_addr + ADDR_W'(1);
            bus.rd_b_addr <= bus.rd_b_addr + ADDR_W'(1);
            d_ptr         <= d_ptr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // done is high in the cycle of the last write.
          if (bus.done) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        FIN: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vfmul_sequencer.sv
// tb_vfmul_sequencer: directed bench with register file and multiplier stub.
// Drives at posedge+1, monitors at negedge.
module tb_vfmul_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vfmul_sequencer_if #(
    .ELEM_W(32), .ADDR_W(5), .VL_W(6)
  ) bus ();

  vfmul_sequencer #(
    .ELEM_W(32), .ADDR_W(5), .MAX_VL(32), .VL_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Register file: 1-cycle read latency, bulk preload from pre[].
  logic [31:0] mem [32];
  logic [31:0] pre [32];
  logic        ld = 1'b0;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 32; i++) mem[i] <= pre[i];
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    bus.rd_a_data <= mem[bus.rd_a_addr];
    bus.rd_b_data <= mem[bus.rd_b_addr];
  end

  // Multiplier stub: ordered (a,b) products used by the vectors.
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'h3F800000_3F800000: return 32'h3F800000;
      64'h7FC00000_3F800000: return 32'h7FC00000;
      64'h7F800000_40000000: return 32'h7F800000;
      default:               return 32'h00000000;
    endcase
  endfunction

  always_comb bus.mul_y = fmul(bus.mul_a, bus.mul_b);

  // Monitor.
  int          cyc = 0;
  int          acc_cyc = -1;
  int          acc_n = 0;
  int          wn = 0;
  int          dn = 0;
  int          done_cyc = 0;
  logic [4:0]  w_addr [256];
  logic [31:0] w_data [256];
  int          w_cyc  [256];
  logic [4:0]  rda    [48];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_cyc = cyc;
      acc_n++;
    end
    if (acc_cyc >= 0 && cyc - acc_cyc >= 1 && cyc - acc_cyc < 48)
      rda[cyc - acc_cyc] = bus.rd_a_addr;
    if (bus.wr_en && wn < 256) begin
      w_addr[wn] = bus.wr_addr;
      w_data[wn] = bus.wr_data;
      w_cyc[wn]  = cyc;
      wn++;
    end
    if (bus.done) begin
      dn++;
      done_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_pre(input logic [31:0] v);
    for (int i = 0; i < 32; i++) pre[i] = v;
  endtask

  task automatic load();
    tick(1);
    ld = 1'b1;
    tick(1);
    ld = 1'b0;
  endtask

  task automatic drive(input int vl, input int a,
                       input int b, input int d);
    bus.cmd_vl     = 6'(vl);
    bus.cmd_a_base = 5'(a);
    bus.cmd_b_base = 5'(b);
    bus.cmd_d_base = 5'(d);
  endtask

  // Returns in the cycle after accept.
  task automatic send_cmd(input int vl, input int a,
                          input int b, input int d);
    tick(1);
    drive(vl, a, b, d);
    bus.cmd_valid = 1'b1;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!bus.cmd_ready && k < 200) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: cmd_ready=%b want 1", nm, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    n_checks++;
    if ({bus.cmd_ready, bus.busy, bus.done, bus.wr_en,
         bus.flag_nan, bus.flag_inf} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 100000",
               {bus.cmd_ready, bus.busy, bus.done, bus.wr_en,
                bus.flag_nan, bus.flag_inf});
    end
    n_checks++;
    if ({bus.mul_a, bus.mul_b, bus.wr_data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {bus.mul_a, bus.mul_b, bus.wr_data});
    end
    n_checks++;
    if ({bus.rd_a_addr, bus.rd_b_addr, bus.wr_addr} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 0",
               {bus.rd_a_addr, bus.rd_b_addr, bus.wr_addr});
    end
    tick(1);
    reset = 1'b0;
    tick(2);
    n_checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 10",
               {bus.cmd_ready, bus.busy});
    end
  endtask

  task automatic test_basic();
    int w0, d0;
    fill_pre(32'h0);
    pre[0] = 32'h40000000;
    pre[1] = 32'h3FC00000;
    pre[4] = 32'h40400000;
    pre[5] = 32'h3FC00000;
    load();
    w0 = wn;
    d0 = dn;
    send_cmd(2, 0, 4, 8);
    wait_idle("basic");
    n_checks++;
    if (wn - w0 !== 2) begin
      n_fail++;
      $display("FAIL basic_nwr: got %0d want 2", wn - w0);
    end
    n_checks++;
    if ({w_addr[w0], w_data[w0]} !== {5'd8, 32'h40C00000}) begin
      n_fail++;
      $display("FAIL basic_wr0: got %0d/%h want 8/40c00000",
               w_addr[w0], w_data[w0]);
    end
    n_checks++;
    if ({w_addr[w0+1], w_data[w0+1]} !== {5'd9, 32'h40100000}) begin
      n_fail++;
      $display("FAIL basic_wr1: got %0d/%h want 9/40100000",
               w_addr[w0+1], w_data[w0+1]);
    end
    n_checks++;
    if (w_cyc[w0] - acc_cyc !== 4) begin
      n_fail++;
      $display("FAIL basic_lat: got %0d want 4", w_cyc[w0] - acc_cyc);
    end
    n_checks++;
    if (dn - d0 !== 1 || done_cyc !== w_cyc[w0+1]) begin
      n_fail++;
      $display("FAIL basic_done: n=%0d at %0d want 1 at %0d",
               dn - d0, done_cyc, w_cyc[w0+1]);
    end
    n_checks++;
    if ({bus.flag_nan, bus.flag_inf} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_flags: got %b want 00",
               {bus.flag_nan, bus.flag_inf});
    end
    n_checks++;
    if (mem[9] !== 32'h40100000) begin
      n_fail++;
      $display("FAIL basic_mem9: got %h want 40100000", mem[9]);
    end
  endtask

  task automatic test_throughput_wrap();
    int w0, bad;
    fill_pre(32'h3F800000);
    load();
    w0 = wn;
    send_cmd(32, 30, 0, 16);
    wait_idle("wrap");
    n_checks++;
    if (wn - w0 !== 32) begin
      n_fail++;
      $display("FAIL wrap_nwr: got %0d want 32", wn - w0);
    end
    n_checks++;
    if (w_cyc[w0+31] - w_cyc[w0] !== 31 || w_cyc[w0] - acc_cyc !== 4) begin
      n_fail++;
      $display("FAIL wrap_stream: span %0d first %0d want 31/4",
               w_cyc[w0+31] - w_cyc[w0], w_cyc[w0] - acc_cyc);
    end
    n_checks++;
    if (done_cyc - acc_cyc !== 35) begin
      n_fail++;
      $display("FAIL wrap_done: got %0d want 35", done_cyc - acc_cyc);
    end
    n_checks++;
    if ({rda[1], rda[2], rda[3], rda[32]} !==
        {5'd30, 5'd31, 5'd0, 5'd29}) begin
      n_fail++;
      $display("FAIL wrap_rd: got %0d %0d %0d %0d want 30 31 0 29",
               rda[1], rda[2], rda[3], rda[32]);
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (w_data[w0+i] !== 32'h3F800000 ||
          w_addr[w0+i] !== 5'((16 + i) % 32)) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL wrap_wr: %0d bad writes want 0", bad);
    end
  endtask

  task automatic test_exceptions();
    int w0;
    fill_pre(32'h0);
    pre[0] = 32'h7FC00000;
    pre[1] = 32'h7F800000;
    pre[4] = 32'h3F800000;
    pre[5] = 32'h40000000;
    load();
    w0 = wn;
    send_cmd(2, 0, 4, 10);
    wait_idle("exc");
    n_checks++;
    if ({w_data[w0], w_data[w0+1]} !== {32'h7FC00000, 32'h7F800000}) begin
      n_fail++;
      $display("FAIL exc_data: got %h %h want 7fc00000 7f800000",
               w_data[w0], w_data[w0+1]);
    end
    n_checks++;
    if ({bus.flag_nan, bus.flag_inf} !== 2'b11) begin
      n_fail++;
      $display("FAIL exc_flags: got %b want 11",
               {bus.flag_nan, bus.flag_inf});
    end
    tick(5);
    n_checks++;
    if ({bus.flag_nan, bus.flag_inf} !== 2'b11) begin
      n_fail++;
      $display("FAIL exc_hold: got %b want 11",
               {bus.flag_nan, bus.flag_inf});
    end
  endtask

  task automatic test_vl0_clamp();
    int w0;
    logic [4:0] ra;
    ra = bus.rd_a_addr;
    w0 = wn;
    send_cmd(0, 7, 7, 7);
    n_checks++;
    if ({bus.done, bus.cmd_ready, bus.flag_nan, bus.flag_inf} !== 4'b1000) begin
      n_fail++;
      $display("FAIL vl0_c1: done/rdy/nan/inf %b want 1000",
               {bus.done, bus.cmd_ready, bus.flag_nan, bus.flag_inf});
    end
    tick(1);
    n_checks++;
    if ({bus.done, bus.cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL vl0_c2: done/rdy %b want 01",
               {bus.done, bus.cmd_ready});
    end
    tick(3);
    n_checks++;
    if (wn !== w0 || bus.rd_a_addr !== ra) begin
      n_fail++;
      $display("FAIL vl0_quiet: writes %0d addr %0d want 0/%0d",
               wn - w0, bus.rd_a_addr, ra);
    end
    fill_pre(32'h3F800000);
    load();
    w0 = wn;
    send_cmd(40, 0, 0, 20);
    wait_idle("clamp");
    n_checks++;
    if (wn - w0 !== 32 || done_cyc - acc_cyc !== 35) begin
      n_fail++;
      $display("FAIL clamp: writes %0d done@%0d want 32/35",
               wn - w0, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    fill_pre(32'h3F800000);
    load();
    d0 = dn;
    send_cmd(16, 0, 0, 0);
    tick(5);
    n_checks++;
    if (bus.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: wr_en %b want 1", bus.wr_en);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.wr_en, bus.busy, bus.cmd_ready, bus.done} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_async: wr/busy/rdy/done %b want 0010",
               {bus.wr_en, bus.busy, bus.cmd_ready, bus.done});
    end
    tick(1);
    reset = 1'b0;
    tick(25);
    n_checks++;
    if (dn !== d0 || {bus.cmd_ready, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_after: done %0d rdy/busy %b want 0/10",
               dn - d0, {bus.cmd_ready, bus.busy});
    end
    fill_pre(32'h0);
    pre[3] = 32'h40000000;
    pre[7] = 32'h40400000;
    load();
    w0 = wn;
    d0 = dn;
    send_cmd(1, 3, 7, 12);
    wait_idle("rst_next");
    n_checks++;
    if (wn - w0 !== 1 || dn - d0 !== 1 ||
        {w_addr[w0], w_data[w0]} !== {5'd12, 32'h40C00000}) begin
      n_fail++;
      $display("FAIL rst_next: n=%0d d=%0d %0d/%h want 1 1 12/40c00000",
               wn - w0, dn - d0, w_addr[w0], w_data[w0]);
    end
  endtask

  task automatic test_back_to_back();
    int a0, w0, k;
    fill_pre(32'h0);
    pre[0]  = 32'h40000000;
    pre[1]  = 32'h3FC00000;
    pre[2]  = 32'h3F800000;
    pre[3]  = 32'h40000000;
    pre[8]  = 32'h40400000;
    pre[9]  = 32'h3FC00000;
    pre[10] = 32'h3F800000;
    pre[11] = 32'h40400000;
    load();
    a0 = acc_n;
    w0 = wn;
    tick(1);
    drive(4, 0, 8, 0);
    bus.cmd_valid = 1'b1;
    k = 0;
    tick(1);
    while (!bus.done && k < 100) begin
      tick(1);
      k++;
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_done: timeout done=%b want 1", bus.done);
    end
    wait_idle("hold");
    tick(4);
    n_checks++;
    if (acc_n - a0 !== 1 || wn - w0 !== 4) begin
      n_fail++;
      $display("FAIL hold_once: acc %0d wr %0d want 1/4",
               acc_n - a0, wn - w0);
    end
    n_checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !==
        {32'h40C00000, 32'h40100000, 32'h3F800000, 32'h40C00000}) begin
      n_fail++;
      $display("FAIL hold_inplace: got %h %h %h %h want 40c00000 40100000 3f800000 40c00000",
               mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throughput_wrap();
    test_exceptions();
    test_vl0_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
